// File: rtl/alu_issue_controller_pkg.sv
// Shared types and constants for the ALU issue controller and its instruction decoder.
// Instruction layout: {opcode[18:14], rd[13:10], rs1[9:6], rs2[5:2], rsvd[1:0]}.
package alu_issue_controller_pkg;

    localparam int WORD_SIZE  = 19;
    localparam int OPC_W      = 5;
    localparam int REG_ADDR_W = 4;
    localparam int RSVD_W     = WORD_SIZE - OPC_W - 3 * REG_ADDR_W;

    // Function code within the unit picked by MODE (arithmetic or logical).
    typedef enum logic [2:0] {
        ALU_FN_0 = 3'd0,
        ALU_FN_1 = 3'd1,
        ALU_FN_2 = 3'd2,
        ALU_FN_3 = 3'd3,
        ALU_FN_4 = 3'd4,
        ALU_FN_5 = 3'd5,
        ALU_FN_6 = 3'd6,
        ALU_FN_7 = 3'd7
    } alu_sel_e;

    typedef struct packed {
        logic [OPC_W-1:0]      opcode;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [RSVD_W-1:0]     rsvd;
    } instr_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        READ   = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4
    } issue_state_e;

    // Opcodes with the top bit clear belong to the ALU.
    function automatic logic is_alu_opcode(input logic [OPC_W-1:0] opc);
        return ~opc[OPC_W-1];
    endfunction

endpackage

// File: rtl/alu_issue_controller_decoder.sv
// Combinational field extraction for one instruction word.
// Splits the opcode into the MODE bit and the ALU_SEL function code.
module alu_instr_decoder
    import alu_issue_controller_pkg::*;
(
    input  instr_t                instr_i,
    output logic                  is_alu_o,
    output logic                  mode_o,
    output alu_sel_e              sel_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [REG_ADDR_W-1:0] rs1_o,
    output logic [REG_ADDR_W-1:0] rs2_o
);

    logic unused_rsvd;

    always_comb begin
        is_alu_o = is_alu_opcode(instr_i.opcode);
        mode_o   = instr_i.opcode[3];
        sel_o    = alu_sel_e'(instr_i.opcode[2:0]);
        rd_o     = instr_i.rd;
        rs1_o    = instr_i.rs1;
        rs2_o    = instr_i.rs2;
    end

    // The low two bits carry no meaning for the ALU path.
    assign unused_rsvd = ^instr_i.rsvd;

endmodule

// File: rtl/alu_issue_controller.sv
// Five-state issue sequencer: accept, decode, read operands, execute on the ALU, write back.
// Operand, control and result registers live here; field extraction is in alu_instr_decoder.
module alu_issue_controller
    import alu_issue_controller_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [WORD_SIZE-1:0]  instr,
    output logic [REG_ADDR_W-1:0] rf_raddr1,
    output logic [REG_ADDR_W-1:0] rf_raddr2,
    input  logic [WORD_SIZE-1:0]  rf_rdata1,
    input  logic [WORD_SIZE-1:0]  rf_rdata2,
    output logic                  alu_mode,
    output logic [2:0]            alu_sel,
    output logic [WORD_SIZE-1:0]  alu_op1,
    output logic [WORD_SIZE-1:0]  alu_op2,
    input  logic [WORD_SIZE-1:0]  alu_result,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [WORD_SIZE-1:0]  rf_wdata,
    output logic                  done,
    output logic                  illegal
);

    issue_state_e          state_q, state_d;
    instr_t                instr_q, instr_d;
    logic [REG_ADDR_W-1:0] raddr1_q, raddr1_d;
    logic [REG_ADDR_W-1:0] raddr2_q, raddr2_d;
    logic [WORD_SIZE-1:0]  op1_q, op1_d;
    logic [WORD_SIZE-1:0]  op2_q, op2_d;
    logic                  mode_q, mode_d;
    alu_sel_e              sel_q, sel_d;
    logic [WORD_SIZE-1:0]  result_q, result_d;

    logic                  dec_is_alu;
    logic                  dec_mode;
    alu_sel_e              dec_sel;
    logic [REG_ADDR_W-1:0] dec_rd;
    logic [REG_ADDR_W-1:0] dec_rs1;
    logic [REG_ADDR_W-1:0] dec_rs2;

    alu_instr_decoder u_decoder (
        .instr_i  (instr_q),
        .is_alu_o (dec_is_alu),
        .mode_o   (dec_mode),
        .sel_o    (dec_sel),
        .rd_o     (dec_rd),
        .rs1_o    (dec_rs1),
        .rs2_o    (dec_rs2)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid) state_d = DECODE;
            DECODE:  state_d = dec_is_alu ? READ : IDLE;
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == IDLE);
        illegal     = (state_q == DECODE) && !dec_is_alu;
        done        = (state_q == WB);
        // R0 is hardwired to zero, so a write to it is suppressed but still retires.
        rf_we       = (state_q == WB) && (dec_rd != '0);
        rf_waddr    = dec_rd;
        rf_wdata    = result_q;
        rf_raddr1   = raddr1_q;
        rf_raddr2   = raddr2_q;
        if ((state_q == DECODE) && dec_is_alu) begin
            rf_raddr1 = dec_rs1;
            rf_raddr2 = dec_rs2;
        end
        alu_op1  = op1_q;
        alu_op2  = op2_q;
        alu_mode = mode_q;
        alu_sel  = sel_q;
    end

    always_comb begin
        instr_d  = instr_q;
        raddr1_d = raddr1_q;
        raddr2_d = raddr2_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        mode_d   = mode_q;
        sel_d    = sel_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (instr_valid) instr_d = instr_t'(instr);
            end
            DECODE: begin
                if (dec_is_alu) begin
                    raddr1_d = dec_rs1;
                    raddr2_d = dec_rs2;
                end
            end
            READ: begin
                op1_d  = (dec_rs1 == '0) ? '0 : rf_rdata1;
                op2_d  = (dec_rs2 == '0) ? '0 : rf_rdata2;
                mode_d = dec_mode;
                sel_d  = dec_sel;
            end
            EXEC: begin
                result_d = alu_result;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            instr_q  <= '0;
            raddr1_q <= '0;
            raddr2_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            mode_q   <= 1'b0;
            sel_q    <= ALU_FN_0;
            result_q <= '0;
        end else begin
            instr_q  <= instr_d;
            raddr1_q <= raddr1_d;
            raddr2_q <= raddr2_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            mode_q   <= mode_d;
            sel_q    <= sel_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_controller.sv
// Directed bench for alu_issue_controller with a behavioural register file and ALU stand-in.
module tb_alu_issue_controller;

    logic        CLK;
    logic        RESET;
    logic        instr_valid;
    logic        instr_ready;
    logic [18:0] instr;
    logic [3:0]  rf_raddr1, rf_raddr2;
    logic [18:0] rf_rdata1, rf_rdata2;
    logic        alu_mode;
    logic [2:0]  alu_sel;
    logic [18:0] alu_op1, alu_op2;
    logic [18:0] alu_result;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [18:0] rf_wdata;
    logic        done;
    logic        illegal;

    logic [18:0] rf [0:15];
    int n_chk = 0;
    int n_fail = 0;

    alu_issue_controller dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .alu_mode    (alu_mode),
        .alu_sel     (alu_sel),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_result  (alu_result),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .done        (done),
        .illegal     (illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file returns raw contents, including R0; zeroing R0 is the controller's job.
    always_comb begin
        rf_rdata1 = rf[rf_raddr1];
        rf_rdata2 = rf[rf_raddr2];
    end

    // Stand-in ALU: mode 0 = add/sub, mode 1 = and/or/xor/not.
    always_comb begin
        alu_result = alu_op1 + alu_op2;
        if (!alu_mode) begin
            if (alu_sel == 3'd1) alu_result = alu_op1 - alu_op2;
        end else begin
            case (alu_sel)
                3'd0:    alu_result = alu_op1 & alu_op2;
                3'd1:    alu_result = alu_op1 | alu_op2;
                3'd2:    alu_result = alu_op1 ^ alu_op2;
                default: alu_result = ~alu_op1;
            endcase
        end
    end

    function automatic logic [18:0] mk(input logic [4:0] opc, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2);
        return {opc, rd, rs1, rs2, 2'b00};
    endfunction

    // Entered at a falling edge; returns at the falling edge of cycle N+1.
    task automatic send(input logic [18:0] w);
        int k = 0;
        while (!instr_ready && k < 8) begin
            @(negedge CLK);
            k++;
        end
        n_chk++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL send_wait_ready: got %b want 1", instr_ready); end
        instr = w;
        instr_valid = 1'b1;
        @(negedge CLK);
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        n_chk++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
        n_chk++; if ({rf_we, done, illegal} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {rf_we, done, illegal}); end
        n_chk++; if ({alu_op1, alu_op2, rf_wdata} !== 57'd0) begin n_fail++; $display("FAIL reset_data: got %h %h %h want 0", alu_op1, alu_op2, rf_wdata); end
        n_chk++; if ({alu_mode, alu_sel, rf_raddr1, rf_raddr2, rf_waddr} !== 16'd0) begin n_fail++; $display("FAIL reset_ctrl: got %b %h %h %h %h want 0", alu_mode, alu_sel, rf_raddr1, rf_raddr2, rf_waddr); end
    endtask

    task automatic test_add();
        rf[1] = 19'd5;
        rf[2] = 19'd7;
        send(mk(5'b00000, 4'd3, 4'd1, 4'd2));
        n_chk++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL add_decode_ready: got %b want 0", instr_ready); end
        n_chk++; if ({rf_raddr1, rf_raddr2} !== 8'h12) begin n_fail++; $display("FAIL add_raddr: got %h want 12", {rf_raddr1, rf_raddr2}); end
        repeat (2) @(negedge CLK);
        n_chk++; if ({alu_mode, alu_sel} !== 4'b0000) begin n_fail++; $display("FAIL add_exec_ctrl: got %b want 0000", {alu_mode, alu_sel}); end
        n_chk++; if (alu_op1 !== 19'd5 || alu_op2 !== 19'd7) begin n_fail++; $display("FAIL add_exec_ops: got %h %h want 5 7", alu_op1, alu_op2); end
        n_chk++; if ({rf_we, done} !== 2'b00) begin n_fail++; $display("FAIL add_exec_early: got %b want 00", {rf_we, done}); end
        @(negedge CLK);
        n_chk++; if ({rf_we, done} !== 2'b11) begin n_fail++; $display("FAIL add_wb_pulse: got %b want 11", {rf_we, done}); end
        n_chk++; if (rf_waddr !== 4'd3 || rf_wdata !== 19'd12) begin n_fail++; $display("FAIL add_wb_data: got %h %h want 3 0000c", rf_waddr, rf_wdata); end
        @(negedge CLK);
        n_chk++; if ({instr_ready, rf_we, done} !== 3'b100) begin n_fail++; $display("FAIL add_retire: got %b want 100", {instr_ready, rf_we, done}); end
    endtask

    task automatic test_logical();
        rf[1] = 19'h0F0F0;
        rf[2] = 19'h00FF0;
        send(mk(5'b01001, 4'd6, 4'd1, 4'd2));
        repeat (2) @(negedge CLK);
        n_chk++; if ({alu_mode, alu_sel} !== 4'b1001) begin n_fail++; $display("FAIL logic_exec_ctrl: got %b want 1001", {alu_mode, alu_sel}); end
        n_chk++; if (alu_op1 !== 19'h0F0F0 || alu_op2 !== 19'h00FF0) begin n_fail++; $display("FAIL logic_exec_ops: got %h %h want 0f0f0 00ff0", alu_op1, alu_op2); end
        @(negedge CLK);
        n_chk++; if (rf_we !== 1'b1 || rf_waddr !== 4'd6 || rf_wdata !== 19'h0FFF0) begin n_fail++; $display("FAIL logic_wb: got %b %h %h want 1 6 0fff0", rf_we, rf_waddr, rf_wdata); end
        @(negedge CLK);
        n_chk++; if (alu_mode !== 1'b1 || alu_op1 !== 19'h0F0F0) begin n_fail++; $display("FAIL logic_hold: got %b %h want 1 0f0f0", alu_mode, alu_op1); end
    endtask

    task automatic test_illegal();
        send(mk(5'b10000, 4'd7, 4'd9, 4'd10));
        n_chk++; if ({illegal, done, rf_we} !== 3'b100) begin n_fail++; $display("FAIL illegal_pulse: got %b want 100", {illegal, done, rf_we}); end
        n_chk++; if (rf_raddr1 !== 4'd1 || rf_raddr2 !== 4'd2) begin n_fail++; $display("FAIL illegal_raddr_hold: got %h %h want 1 2", rf_raddr1, rf_raddr2); end
        @(negedge CLK);
        n_chk++; if ({instr_ready, illegal, done, rf_we} !== 4'b1000) begin n_fail++; $display("FAIL illegal_return: got %b want 1000", {instr_ready, illegal, done, rf_we}); end
    endtask

    task automatic test_r0();
        rf[0] = 19'h7FFFF;
        rf[2] = 19'd7;
        send(mk(5'b00000, 4'd0, 4'd0, 4'd2));
        repeat (2) @(negedge CLK);
        n_chk++; if (alu_op1 !== 19'd0 || alu_op2 !== 19'd7) begin n_fail++; $display("FAIL r0_ops: got %h %h want 0 7", alu_op1, alu_op2); end
        @(negedge CLK);
        n_chk++; if ({done, rf_we} !== 2'b10) begin n_fail++; $display("FAIL r0_wb: got %b want 10", {done, rf_we}); end
        n_chk++; if (rf_wdata !== 19'd7) begin n_fail++; $display("FAIL r0_wdata: got %h want 7", rf_wdata); end
        @(negedge CLK);
        rf[0] = 19'd0;
    endtask

    task automatic test_back_to_back();
        int acc_n = 0;
        int acc_cyc [2] = '{-1, -1};
        int done_n = 0;
        logic [18:0] wd [2] = '{19'd0, 19'd0};
        logic [3:0]  wa [2] = '{4'd0, 4'd0};
        rf[1] = 19'd5;
        rf[2] = 19'd7;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (instr_ready && cyc < 10) begin
                if (acc_n < 2) acc_cyc[acc_n] = cyc;
                acc_n++;
            end
            if (done) begin
                if (done_n < 2) begin
                    wd[done_n] = rf_wdata;
                    wa[done_n] = rf_waddr;
                end
                done_n++;
            end
            instr_valid = (cyc < 10);
            instr = (cyc == 0) ? mk(5'b00000, 4'd4, 4'd1, 4'd2) : mk(5'b00001, 4'd5, 4'd2, 4'd1);
            @(negedge CLK);
        end
        instr_valid = 1'b0;
        n_chk++; if (acc_n !== 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 2", acc_n); end
        n_chk++; if (acc_cyc[0] !== 0 || acc_cyc[1] !== 5) begin n_fail++; $display("FAIL b2b_accept_cycles: got %0d %0d want 0 5", acc_cyc[0], acc_cyc[1]); end
        n_chk++; if (done_n !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_n); end
        n_chk++; if (wd[0] !== 19'd12 || wa[0] !== 4'd4) begin n_fail++; $display("FAIL b2b_first_wb: got %h %h want 0000c 4", wd[0], wa[0]); end
        n_chk++; if (wd[1] !== 19'd2 || wa[1] !== 4'd5) begin n_fail++; $display("FAIL b2b_second_wb: got %h %h want 00002 5", wd[1], wa[1]); end
    endtask

    task automatic test_reset_mid();
        rf[1] = 19'd5;
        rf[2] = 19'd7;
        send(mk(5'b01000, 4'd3, 4'd1, 4'd2));
        repeat (2) @(negedge CLK);
        n_chk++; if (alu_op1 !== 19'd5 || alu_mode !== 1'b1) begin n_fail++; $display("FAIL rstmid_exec: got %h %b want 5 1", alu_op1, alu_mode); end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        n_chk++; if ({instr_ready, rf_we, done, illegal} !== 4'b1000) begin n_fail++; $display("FAIL rstmid_ctrl: got %b want 1000", {instr_ready, rf_we, done, illegal}); end
        n_chk++; if ({alu_op1, alu_op2, rf_wdata} !== 57'd0) begin n_fail++; $display("FAIL rstmid_data: got %h %h %h want 0", alu_op1, alu_op2, rf_wdata); end
        n_chk++; if ({alu_mode, alu_sel, rf_raddr1, rf_raddr2, rf_waddr} !== 16'd0) begin n_fail++; $display("FAIL rstmid_fields: got %b %h %h %h %h want 0", alu_mode, alu_sel, rf_raddr1, rf_raddr2, rf_waddr); end
        @(negedge CLK);
        n_chk++; if ({rf_we, done} !== 2'b00) begin n_fail++; $display("FAIL rstmid_no_retire: got %b want 00", {rf_we, done}); end
        RESET = 1'b1;
        instr_valid = 1'b1;
        instr = mk(5'b00000, 4'd3, 4'd1, 4'd2);
        @(negedge CLK);
        RESET = 1'b0;
        instr_valid = 1'b0;
        n_chk++; if (instr_ready !== 1'b1 || rf_raddr1 !== 4'd0) begin n_fail++; $display("FAIL reset_beats_valid: got %b %h want 1 0", instr_ready, rf_raddr1); end
        @(negedge CLK);
        n_chk++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_beats_valid_idle: got %b want 1", instr_ready); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 19'd0;
        test_reset();
        test_add();
        test_logical();
        test_illegal();
        test_r0();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
